// File: rtl/nios2_dbg_pkg.sv
// Shared definitions for the Nios II debug command path (system-clock side).
// Contents: virtual-IR command codes, jdo bit positions used by the decoder,
// and the reference {ir, data} command layout for the 38-bit / 2-bit IR build.
package nios2_dbg_pkg;

  // Virtual IR command codes
  localparam int IR_OCIMEM    = 0;
  localparam int IR_TRACEMEM  = 1;
  localparam int IR_BREAK     = 2;
  localparam int IR_TRACECTRL = 3;

  // jdo bit positions
  localparam int JDO_OCI_B      = 35;  // OCIMEM: select port-b action
  localparam int JDO_OCI_A      = 34;  // OCIMEM: select port-a action
  localparam int JDO_BRK_ACT    = 37;  // BREAK: action / no-action
  localparam int JDO_BRK_IDX_HI = 36;  // BREAK: channel index msb
  localparam int JDO_BRK_IDX_LO = 34;  // BREAK: channel index lsb
  localparam int JDO_TRACE_EN   = 15;  // TRACECTRL: take action

  // Reference command layout (default widths)
  localparam int CMD_SR_W = 38;
  localparam int CMD_IR_W = 2;

  typedef struct packed {
    logic [CMD_IR_W-1:0] ir;
    logic [CMD_SR_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/nios2_dbg_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level strobe plus registered rising-edge detect.
// Ports: clk, reset (async, active-high), level (async input), rise (1-cycle pulse per high level).
// The pulse appears STAGES+1 edges after the first edge that samples level high.
module nios2_dbg_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain  <= '0;
      last_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      chain  <= {chain[STAGES-2:0], level};
      last_q <= chain[STAGES-1];
      // One pulse per high level: last stage high while its delayed copy is still low
      rise   <= chain[STAGES-1] & ~last_q;
    end
  end

endmodule

// File: rtl/nios2_debug_cmd_sync.sv
// System-clock side of the Nios II JTAG debug slave: resynchronises update-DR/IR strobes,
// queues {ir, sr} commands in a small FIFO, pops them under cmd_valid/cmd_ready and decodes
// each popped command into registered one-cycle action strobes; sticky overflow/bad_cmd flags.
module nios2_debug_cmd_sync
  import nios2_dbg_pkg::*;
#(
  parameter int SR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int NUM_BRK     = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [SR_WIDTH-1:0]           sr,
  input  logic [IR_WIDTH-1:0]           ir_in,
  input  logic                          vs_udr,
  input  logic                          vs_uir,
  input  logic                          cmd_ready,
  input  logic                          clr_err,
  output logic                          cmd_valid,
  output logic [SR_WIDTH-1:0]           jdo,
  output logic [IR_WIDTH-1:0]           cmd_ir,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ir_updated,
  output logic                          take_action_ocimem_a,
  output logic                          take_action_ocimem_b,
  output logic                          take_no_action_ocimem_a,
  output logic [NUM_BRK-1:0]            take_action_break,
  output logic [NUM_BRK-1:0]            take_no_action_break,
  output logic                          take_action_tracectrl,
  output logic                          overflow,
  output logic                          bad_cmd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = 1;
  localparam logic [AW:0]   LVL_ONE    = 1;
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [IR_WIDTH-1:0] ir;
    logic [SR_WIDTH-1:0] data;
  } entry_t;

  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          udr_rise, uir_rise;
  logic          push, pop, full, empty, accept;

  // Strobe decode (next-state of the registered strobes)
  logic [2:0]         brk_idx;
  logic [NUM_BRK-1:0] brk_hit;
  logic               nxt_act_a, nxt_act_b, nxt_noact_a, nxt_trace, nxt_bad;
  logic [NUM_BRK-1:0] nxt_act_brk, nxt_noact_brk;

  nios2_dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_udr (
    .clk   (clk),
    .reset (reset),
    .level (vs_udr),
    .rise  (udr_rise)
  );

  nios2_dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_uir (
    .clk   (clk),
    .reset (reset),
    .level (vs_uir),
    .rise  (uir_rise)
  );

  assign empty  = (level == '0);
  assign full   = (level == FULL_LEVEL);
  assign push   = udr_rise;
  assign pop    = cmd_valid & cmd_ready;
  // A pop frees the head slot in the same cycle, so a push at full still fits
  assign accept = push & (~full | pop);

  assign cmd_valid  = ~empty;
  assign fifo_level = level;
  assign head       = empty ? '0 : mem[rd_ptr];
  assign jdo        = head.data;
  assign cmd_ir     = head.ir;

  // Storage has no reset: contents are only observable through head while non-empty
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= '{ir: ir_in, data: sr};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
      case ({accept, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      if (push & full & ~pop) overflow <= 1'b1;
      else if (clr_err)       overflow <= 1'b0;
    end
  end

  always_comb begin
    nxt_act_a     = 1'b0;
    nxt_act_b     = 1'b0;
    nxt_noact_a   = 1'b0;
    nxt_act_brk   = '0;
    nxt_noact_brk = '0;
    nxt_trace     = 1'b0;
    nxt_bad       = 1'b0;
    brk_idx       = head.data[JDO_BRK_IDX_HI:JDO_BRK_IDX_LO];
    // brk_hit is all-zero when the index names a channel that does not exist
    for (int b = 0; b < NUM_BRK; b++) begin
      brk_hit[b] = (brk_idx == 3'(b));
    end
    if (pop) begin
      if (head.ir == IR_WIDTH'(IR_OCIMEM)) begin
        if (head.data[JDO_OCI_B])      nxt_act_b   = 1'b1;
        else if (head.data[JDO_OCI_A]) nxt_act_a   = 1'b1;
        else                           nxt_noact_a = 1'b1;
      end else if (head.ir == IR_WIDTH'(IR_BREAK)) begin
        if (|brk_hit) begin
          if (head.data[JDO_BRK_ACT]) nxt_act_brk   = brk_hit;
          else                        nxt_noact_brk = brk_hit;
        end else begin
          nxt_bad = 1'b1;
        end
      end else if (head.ir == IR_WIDTH'(IR_TRACECTRL)) begin
        nxt_trace = head.data[JDO_TRACE_EN];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      take_action_ocimem_a    <= 1'b0;
      take_action_ocimem_b    <= 1'b0;
      take_no_action_ocimem_a <= 1'b0;
      take_action_break       <= '0;
      take_no_action_break    <= '0;
      take_action_tracectrl   <= 1'b0;
      ir_updated              <= 1'b0;
      bad_cmd                 <= 1'b0;
    end else begin
      take_action_ocimem_a    <= nxt_act_a;
      take_action_ocimem_b    <= nxt_act_b;
      take_no_action_ocimem_a <= nxt_noact_a;
      take_action_break       <= nxt_act_brk;
      take_no_action_break    <= nxt_noact_brk;
      take_action_tracectrl   <= nxt_trace;
      // Extra register aligns ir_updated with the cmd_valid latency of update-DR
      ir_updated              <= uir_rise;
      if (nxt_bad)      bad_cmd <= 1'b1;
      else if (clr_err) bad_cmd <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nios2_debug_cmd_sync.sv
// Bench for nios2_debug_cmd_sync: directed timing checks plus randomized commands.
// Expected strobes are queued at issue time and consumed by an independent monitor.
module tb_nios2_debug_cmd_sync;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] sr;
  logic [1:0]  ir_in;
  logic        vs_udr, vs_uir, cmd_ready, clr_err;
  logic        cmd_valid;
  logic [37:0] jdo;
  logic [1:0]  cmd_ir;
  logic [2:0]  fifo_level;
  logic        ir_updated;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [3:0]  take_action_break, take_no_action_break;
  logic        take_action_tracectrl, overflow, bad_cmd;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  logic        model_bad = 1'b0;
  logic [11:0] strobes;

  // Layout: [11] act_a [10] act_b [9] noact_a [8:5] act_brk [4:1] noact_brk [0] trace
  assign strobes = {take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
                    take_action_break, take_no_action_break, take_action_tracectrl};

  always #5 clk = ~clk;

  nios2_debug_cmd_sync #(
    .SR_WIDTH(38), .IR_WIDTH(2), .SYNC_STAGES(2), .NUM_BRK(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .sr(sr), .ir_in(ir_in), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .cmd_ready(cmd_ready), .clr_err(clr_err), .cmd_valid(cmd_valid), .jdo(jdo),
    .cmd_ir(cmd_ir), .fifo_level(fifo_level), .ir_updated(ir_updated),
    .take_action_ocimem_a(take_action_ocimem_a), .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a), .take_action_break(take_action_break),
    .take_no_action_break(take_no_action_break), .take_action_tracectrl(take_action_tracectrl),
    .overflow(overflow), .bad_cmd(bad_cmd)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference decode straight from the command rules
  function automatic logic [11:0] model_strobe(input int ir, input logic [37:0] j, output logic bad);
    logic [11:0] r;
    int k;
    r   = '0;
    bad = 1'b0;
    k   = int'(j[36:34]);
    if (ir == 0) begin
      if (j[35])      r[10] = 1'b1;
      else if (j[34]) r[11] = 1'b1;
      else            r[9]  = 1'b1;
    end else if (ir == 2) begin
      if (k < 4) begin
        if (j[37]) r[5 + k] = 1'b1;
        else       r[1 + k] = 1'b1;
      end else begin
        bad = 1'b1;
      end
    end else if (ir == 3) begin
      r[0] = j[15];
    end
    return r;
  endfunction

  // Random command that always yields exactly one strobe
  task automatic rand_good(output logic [1:0] ir, output logic [37:0] j);
    logic [63:0] r;
    int sel;
    r   = {$urandom, $urandom};
    j   = r[37:0];
    sel = $urandom_range(0, 2);
    ir  = (sel == 0) ? 2'd0 : (sel == 1) ? 2'd2 : 2'd3;
    if (ir == 2'd2) j[36:34] = 3'($urandom_range(0, 3));
    if (ir == 2'd3) j[15] = 1'b1;
  endtask

  // One update-DR event: high for 4 cycles, low for 4. expect_out=0 when the
  // command is dropped or discarded before it is ever popped.
  task automatic send(input logic [1:0] ir, input logic [37:0] j, input bit expect_out);
    logic [11:0] e;
    logic b;
    e = model_strobe(int'(ir), j, b);
    if (expect_out) begin
      if (e != '0) exp_q.push_back(e);
      if (b) model_bad = 1'b1;
    end
    @(negedge clk);
    ir_in  = ir;
    sr     = j;
    vs_udr = 1'b1;
    repeat (4) @(negedge clk);
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && strobes != '0) begin
      if (exp_q.size() == 0) begin
        check("strobe_unexpected", strobes, 12'h0);
      end else begin
        check("strobe", strobes, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  gir;
    logic [37:0] gj;
    logic [63:0] r;

    reset = 1'b1; sr = '0; ir_in = '0; vs_udr = 1'b0; vs_uir = 1'b0;
    cmd_ready = 1'b0; clr_err = 1'b0;

    // 1: strobes during reset must not queue anything
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      vs_udr = 1'b1; repeat (3) @(negedge clk);
      vs_udr = 1'b0; repeat (3) @(negedge clk);
    end
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_valid", cmd_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_jdo", jdo, 0);
    check("rst_cmd_ir", cmd_ir, 0);
    check("rst_strobes", strobes, 0);
    check("rst_flags", {overflow, bad_cmd, ir_updated}, 0);

    // 2: break 0 action, latency
    cmd_ready = 1'b1;
    exp_q.push_back(12'h1 << 5);
    @(negedge clk);
    ir_in = 2'd2; sr = 38'h20_0000_0000; vs_udr = 1'b1;
    repeat (3) @(negedge clk);
    check("valid_early", cmd_valid, 0);
    @(negedge clk);
    check("valid_latency", cmd_valid, 1);
    check("head_jdo", jdo, 38'h20_0000_0000);
    check("head_ir", cmd_ir, 2);
    check("level_one", fifo_level, 1);
    vs_udr = 1'b0;
    @(negedge clk);
    check("brk0_strobe", take_action_break, 4'b0001);
    check("popped", cmd_valid, 0);
    @(negedge clk);
    check("brk0_one_cycle", take_action_break, 4'b0000);
    repeat (3) @(negedge clk);

    // ir_updated latency and width
    vs_uir = 1'b1;
    repeat (3) @(negedge clk);
    check("iru_early", ir_updated, 0);
    @(negedge clk);
    check("iru_pulse", ir_updated, 1);
    @(negedge clk);
    check("iru_one_cycle", ir_updated, 0);
    vs_uir = 1'b0;
    repeat (4) @(negedge clk);

    // 3: OCIMEM variants
    send(2'd0, 38'h04_0000_0000, 1'b1);
    send(2'd0, 38'h00_0000_0000, 1'b1);
    send(2'd0, 38'h08_0000_0000, 1'b1);

    // Randomized commands, consumer always ready
    for (int i = 0; i < 20; i++) begin
      r = {$urandom, $urandom};
      send(2'($urandom_range(0, 3)), r[37:0], 1'b1);
      check("rand_level", fifo_level, 0);
      check("rand_bad", bad_cmd, model_bad);
    end
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0; model_bad = 1'b0;

    // 5: break index beyond NUM_BRK
    send(2'd2, 38'h3C_0000_0000, 1'b1);
    check("bad_set", bad_cmd, 1);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0; model_bad = 1'b0;
    check("bad_clr", bad_cmd, 0);

    // 4: overflow with consumer stalled, then ordered drain
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_good(gir, gj);
      send(gir, gj, i < 4);
    end
    check("full_level", fifo_level, 4);
    check("ovf_set", overflow, 1);
    cmd_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("drained_level", fifo_level, 0);
    check("ovf_sticky", overflow, 1);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    check("ovf_clr", overflow, 0);

    // Simultaneous push and pop at full
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_good(gir, gj);
      send(gir, gj, 1'b1);
    end
    rand_good(gir, gj);
    begin
      logic b;
      exp_q.push_back(model_strobe(int'(gir), gj, b));
    end
    @(negedge clk);
    ir_in = gir; sr = gj; vs_udr = 1'b1;
    repeat (3) @(negedge clk);
    cmd_ready = 1'b1;
    @(negedge clk);
    check("pushpop_level", fifo_level, 4);
    check("pushpop_no_ovf", overflow, 0);
    vs_udr = 1'b0;
    repeat (10) @(negedge clk);
    check("pushpop_drained", fifo_level, 0);

    // 6: reset with queued commands and a strobe in flight
    cmd_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_good(gir, gj);
      send(gir, gj, 1'b0);
    end
    check("pre_rst_level", fifo_level, 2);
    @(negedge clk);
    cmd_ready = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_kills_strobe", strobes, 0);
    check("rst_level_zero", fifo_level, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_valid", cmd_valid, 0);
    check("post_rst_strobes", strobes, 0);
    cmd_ready = 1'b0;

    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
